// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
//   Samples one raw, asynchronous, bouncing push-button pin and turns it into
//   clean, registered events for the rest of the board.
//
//   Ports
//     CLK      in   system clock, all logic on the rising edge
//     RST      in   synchronous, active-high reset
//     BTN      in   raw button pin (asynchronous, may bounce)
//     PRESSED  out  debounced level, 1 = button held
//     PRESS    out  one-cycle strobe on each accepted press
//     RELEASE  out  one-cycle strobe on each accepted release
//     LEDR     out  toggles on every accepted press (drives the red LED)
//     COUNT    out  accepted presses modulo 2^CNT_W
//
//   Timing: once the pin settles, the outputs change DEBOUNCE_CYCLES + 3
//   rising edges after the first edge that samples the new pin level.
// -----------------------------------------------------------------------------
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN,
    output logic             PRESSED,
    output logic             PRESS,
    output logic             RELEASE,
    output logic             LEDR,
    output logic [CNT_W-1:0] COUNT
);

    // Debounce counter only has to hold 0 .. DEBOUNCE_CYCLES-1.
    localparam int             DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    // Pin level while the button is not touched.
    localparam logic           IDLE_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_WAIT_DOWN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_WAIT_UP   = 2'd3
    } state_t;

    logic             sync1_r;
    logic             sync2_r;
    logic             pressed_raw_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [DB_W-1:0]  db_cnt_r;
    logic [DB_W-1:0]  db_cnt_nxt_s;
    logic             level_s;
    logic             pressed_r;
    logic             press_r;
    logic             release_r;
    logic             ledr_r;
    logic [CNT_W-1:0] count_r;

    // Two-flop synchronizer for the asynchronous pin; resets to the idle level
    // so a reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= IDLE_LVL;
            sync2_r <= IDLE_LVL;
        end else begin
            sync1_r <= BTN;
            sync2_r <= sync1_r;
        end
    end

    // Normalise polarity: 1 always means "pressed" from here on.
    assign pressed_raw_s = sync2_r ^ IDLE_LVL;

    // Debounce state and qualification counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= ST_UP;
            db_cnt_r <= {DB_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            db_cnt_r <= db_cnt_nxt_s;
        end
    end

    // Next-state logic: a WAIT state must see DEBOUNCE_CYCLES consecutive
    // samples at the new level; any sample at the old level aborts it.
    always_comb begin
        state_nxt_s  = state_r;
        db_cnt_nxt_s = db_cnt_r;
        level_s      = 1'b0;
        case (state_r)
            ST_UP: begin
                level_s = 1'b0;
                if (pressed_raw_s) begin
                    db_cnt_nxt_s = {DB_W{1'b0}};
                    state_nxt_s  = ST_WAIT_DOWN;
                end else begin
                    state_nxt_s  = ST_UP;
                end
            end
            ST_WAIT_DOWN: begin
                level_s = 1'b0;
                if (!pressed_raw_s) begin
                    state_nxt_s  = ST_UP;
                end else if (db_cnt_r == DB_LAST) begin
                    state_nxt_s  = ST_DOWN;
                end else begin
                    db_cnt_nxt_s = db_cnt_r + DB_W'(1);
                end
            end
            ST_DOWN: begin
                level_s = 1'b1;
                if (!pressed_raw_s) begin
                    db_cnt_nxt_s = {DB_W{1'b0}};
                    state_nxt_s  = ST_WAIT_UP;
                end else begin
                    state_nxt_s  = ST_DOWN;
                end
            end
            ST_WAIT_UP: begin
                // Still reported as held until the release qualifies.
                level_s = 1'b1;
                if (pressed_raw_s) begin
                    state_nxt_s  = ST_DOWN;
                end else if (db_cnt_r == DB_LAST) begin
                    state_nxt_s  = ST_UP;
                end else begin
                    db_cnt_nxt_s = db_cnt_r + DB_W'(1);
                end
            end
            default: begin
                level_s      = 1'b0;
                state_nxt_s  = ST_UP;
                db_cnt_nxt_s = {DB_W{1'b0}};
            end
        endcase
    end

    // Registered outputs: strobes come from comparing the new level with the
    // registered one, so they line up with the first cycle PRESSED changes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pressed_r <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            ledr_r    <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
        end else begin
            pressed_r <= level_s;
            press_r   <= level_s & ~pressed_r;
            release_r <= ~level_s & pressed_r;
            if (level_s & ~pressed_r) begin
                ledr_r  <= ~ledr_r;
                count_r <= count_r + CNT_W'(1);
            end else begin
                ledr_r  <= ledr_r;
                count_r <= count_r;
            end
        end
    end

    assign PRESSED = pressed_r;
    assign PRESS   = press_r;
    assign RELEASE = release_r;
    assign LEDR    = ledr_r;
    assign COUNT   = count_r;

endmodule

// File: tb/tb_button_reader.sv
// -----------------------------------------------------------------------------
// tb_button_reader
//   Scoreboard bench for button_reader. Instance A: DEBOUNCE_CYCLES=4,
//   ACTIVE_LOW=1 (strobes expected 7 edges after the first sampling edge).
//   Instance B: DEBOUNCE_CYCLES=1, ACTIVE_LOW=0 (4 edges).
//   Stimulus pushes expected strobe events; monitors pop and compare.
// -----------------------------------------------------------------------------
module tb_button_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_a = 1'b1;
    logic       btn_b = 1'b0;
    logic       a_pressed, a_press, a_release, a_ledr;
    logic [7:0] a_count;
    logic       b_pressed, b_press, b_release, b_ledr;
    logic [7:0] b_count;

    typedef struct {
        int cyc;
        int is_press;
        int cnt;
        int ledr;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    ev_t ev_a;
    ev_t ev_b;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int exp_cnt_a = 0, exp_ledr_a = 0;
    int exp_cnt_b = 0, exp_ledr_b = 0;
    int a_press_seen = 0, a_release_seen = 0;

    button_reader #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .CNT_W(8)) dut_a (
        .CLK(clk), .RST(rst), .BTN(btn_a),
        .PRESSED(a_pressed), .PRESS(a_press), .RELEASE(a_release),
        .LEDR(a_ledr), .COUNT(a_count)
    );

    button_reader #(.DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0), .CNT_W(8)) dut_b (
        .CLK(clk), .RST(rst), .BTN(btn_b),
        .PRESSED(b_pressed), .PRESS(b_press), .RELEASE(b_release),
        .LEDR(b_ledr), .COUNT(b_count)
    );

    always #5 clk = ~clk;

    // Rising-edge index, read on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive instance A pin to a level that will qualify; expect a strobe
    // 7 edges after the next (sampling) edge.
    task automatic edge_a(input logic v);
        ev_t e;
        btn_a = v;
        if (v == 1'b0) begin
            exp_cnt_a  = (exp_cnt_a + 1) % 256;
            exp_ledr_a = exp_ledr_a ^ 1;
        end
        e.cyc = cyc + 1 + 7; e.is_press = (v == 1'b0) ? 1 : 0;
        e.cnt = exp_cnt_a;   e.ledr = exp_ledr_a;
        qa.push_back(e);
    endtask

    // Same for instance B (active high, one-sample debounce: 4 edges).
    task automatic edge_b(input logic v);
        ev_t e;
        btn_b = v;
        if (v == 1'b1) begin
            exp_cnt_b  = (exp_cnt_b + 1) % 256;
            exp_ledr_b = exp_ledr_b ^ 1;
        end
        e.cyc = cyc + 1 + 4; e.is_press = (v == 1'b1) ? 1 : 0;
        e.cnt = exp_cnt_b;   e.ledr = exp_ledr_b;
        qb.push_back(e);
    endtask

    task automatic do_reset();
        cmp("a_pending_before_reset", qa.size(), 0);
        cmp("b_pending_before_reset", qb.size(), 0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_cnt_a = 0; exp_ledr_a = 0;
        exp_cnt_b = 0; exp_ledr_b = 0;
    endtask

    task automatic check_a_idle(input string tag, input int cnt, input int ledr, input int lvl);
        cmp({tag, "_pressed"}, int'(a_pressed), lvl);
        cmp({tag, "_ledr"},    int'(a_ledr),    ledr);
        cmp({tag, "_count"},   int'(a_count),   cnt);
    endtask

    // Monitor A: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (a_press || a_release) begin
            if (a_press)   a_press_seen++;
            if (a_release) a_release_seen++;
            cmp("a_strobe_exclusive", int'(a_press & a_release), 0);
            if (qa.size() == 0) begin
                cmp("a_unexpected_strobe_at_cycle", cyc, -1);
            end else begin
                ev_a = qa.pop_front();
                cmp("a_strobe_cycle",   cyc,              ev_a.cyc);
                cmp("a_strobe_kind",    int'(a_press),    ev_a.is_press);
                cmp("a_strobe_pressed", int'(a_pressed),  ev_a.is_press);
                cmp("a_strobe_count",   int'(a_count),    ev_a.cnt);
                cmp("a_strobe_ledr",    int'(a_ledr),     ev_a.ledr);
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (b_press || b_release) begin
            cmp("b_strobe_exclusive", int'(b_press & b_release), 0);
            if (qb.size() == 0) begin
                cmp("b_unexpected_strobe_at_cycle", cyc, -1);
            end else begin
                ev_b = qb.pop_front();
                cmp("b_strobe_cycle",   cyc,              ev_b.cyc);
                cmp("b_strobe_kind",    int'(b_press),    ev_b.is_press);
                cmp("b_strobe_pressed", int'(b_pressed),  ev_b.is_press);
                cmp("b_strobe_count",   int'(b_count),    ev_b.cnt);
                cmp("b_strobe_ledr",    int'(b_ledr),     ev_b.ledr);
            end
        end
    end

    initial begin
        // Reset state.
        tick(3);
        rst = 1'b0;
        check_a_idle("reset_a", 0, 0, 0);
        cmp("reset_a_press",   int'(a_press),   0);
        cmp("reset_a_release", int'(a_release), 0);
        cmp("reset_b_pressed", int'(b_pressed), 0);
        cmp("reset_b_count",   int'(b_count),   0);
        tick(5);

        // Clean press then release.
        edge_a(1'b0);
        tick(20);
        check_a_idle("clean_press", 1, 1, 1);
        edge_a(1'b1);
        tick(20);
        check_a_idle("clean_release", 1, 1, 0);

        // Bounce rejection: low 3, high 2, low 2, then high.
        do_reset();
        tick(3);
        btn_a = 1'b0; tick(3);
        btn_a = 1'b1; tick(2);
        btn_a = 1'b0; tick(2);
        btn_a = 1'b1; tick(20);
        check_a_idle("bounce_reject", 0, 0, 0);

        // Bounce then settle on press, then clean release.
        for (int i = 0; i < 6; i++) begin
            btn_a = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        edge_a(1'b0);
        tick(20);
        check_a_idle("settle_press", 1, 1, 1);
        edge_a(1'b1);
        tick(20);
        check_a_idle("settle_release", 1, 1, 0);

        // 257 press/release pairs: counter wraps through 255 -> 0.
        do_reset();
        tick(3);
        a_press_seen = 0;
        a_release_seen = 0;
        for (int i = 0; i < 257; i++) begin
            edge_a(1'b0);
            tick(12);
            edge_a(1'b1);
            tick(12);
        end
        check_a_idle("wrap", 1, 1, 0);
        cmp("wrap_press_strobes",   a_press_seen,   257);
        cmp("wrap_release_strobes", a_release_seen, 257);

        // Reset during qualification discards the pending press.
        do_reset();
        tick(3);
        btn_a = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_a_idle("mid_reset", 0, 0, 0);
        cmp("mid_reset_press", int'(a_press), 0);
        edge_a(1'b0);
        tick(20);
        check_a_idle("mid_reset_after", 1, 1, 1);
        edge_a(1'b1);
        tick(20);

        // Polarity and one-sample debounce on instance B.
        do_reset();
        tick(3);
        edge_b(1'b1);
        tick(10);
        cmp("pol_b_pressed", int'(b_pressed), 1);
        edge_b(1'b0);
        tick(10);
        cmp("pol_b_released", int'(b_pressed), 0);
        cmp("pol_b_count",    int'(b_count),   1);
        cmp("pol_b_ledr",     int'(b_ledr),    1);

        tick(5);
        cmp("a_queue_drained", qa.size(), 0);
        cmp("b_queue_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
